// File: rtl/ysyx_22040759_wraxi.sv
// ysyx_22040759_wraxi: AXI4 write-channel initiator.
// Turns one store request (address, RISC-V size, right-aligned data) into an
// AW / W / B transaction with lane-shifted data and byte strobes. A store that
// straddles an 8-byte boundary is issued as a two-beat INCR burst. Completion
// is reported with a one-cycle done pulse plus an error flag from BRESP.

module ysyx_22040759_wraxi #(
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_ID_WIDTH   = 4,
    parameter int AXI_USER_WIDTH = 1
) (
    input  logic                        clk,
    input  logic                        rst,

    // Store request from the arbiter
    input  logic                        wr_addr_valid_i,
    input  logic [AXI_ADDR_WIDTH-1:0]   wr_addr_i,
    input  logic [2:0]                  wr_size_i,
    input  logic [AXI_DATA_WIDTH-1:0]   wr_data_i,
    output logic                        wr_done_o,
    output logic                        wr_err_o,

    // AW channel
    input  logic                        axi_aw_ready_i,
    output logic                        axi_aw_valid_o,
    output logic [AXI_ADDR_WIDTH-1:0]   axi_aw_addr_o,
    output logic [AXI_ID_WIDTH-1:0]     axi_aw_id_o,
    output logic [AXI_USER_WIDTH-1:0]   axi_aw_user_o,
    output logic [7:0]                  axi_aw_len_o,
    output logic [2:0]                  axi_aw_size_o,
    output logic [1:0]                  axi_aw_burst_o,
    output logic [2:0]                  axi_aw_prot_o,
    output logic                        axi_aw_lock_o,
    output logic [3:0]                  axi_aw_cache_o,
    output logic [3:0]                  axi_aw_qos_o,

    // W channel
    input  logic                        axi_w_ready_i,
    output logic                        axi_w_valid_o,
    output logic [AXI_DATA_WIDTH-1:0]   axi_w_data_o,
    output logic [AXI_DATA_WIDTH/8-1:0] axi_w_strb_o,
    output logic                        axi_w_last_o,
    output logic [AXI_USER_WIDTH-1:0]   axi_w_user_o,

    // B channel
    output logic                        axi_b_ready_o,
    input  logic                        axi_b_valid_i,
    input  logic [1:0]                  axi_b_resp_i,
    input  logic [AXI_ID_WIDTH-1:0]     axi_b_id_i,
    input  logic [AXI_USER_WIDTH-1:0]   axi_b_user_i
);

    localparam int StrbWidth = AXI_DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        WRITE = 3'd2,
        RESP  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t state_q;

    // Registered handshake / status outputs
    logic awValid_q;
    logic wValid_q;
    logic bReady_q;
    logic done_q;
    logic err_q;
    logic beat_q;

    // Transaction payload captured when the request is accepted
    logic [AXI_ADDR_WIDTH-1:0]   awAddr_q;
    logic                        cross_q;
    logic [2*AXI_DATA_WIDTH-1:0] wData_q;
    logic [2*StrbWidth-1:0]      wStrb_q;

    // Lane math computed from the live request
    logic [2:0]                  offset;
    logic [StrbWidth-1:0]        baseMask;
    logic [AXI_DATA_WIDTH-1:0]   dataMasked;
    logic [AXI_ADDR_WIDTH-1:0]   awAddr_d;
    logic                        cross_d;
    logic [2*AXI_DATA_WIDTH-1:0] wData_d;
    logic [2*StrbWidth-1:0]      wStrb_d;

    logic lastBeat;
    logic unused_inputs;

    assign offset = wr_addr_i[2:0];

    // Size decode, byte masking of the store data and shifting into lanes
    always_comb begin
        baseMask   = '0;
        dataMasked = '0;
        case (wr_size_i[1:0])
            2'b00:   baseMask = 8'h01;
            2'b01:   baseMask = 8'h03;
            2'b10:   baseMask = 8'h0F;
            default: baseMask = 8'hFF;
        endcase
        for (int i = 0; i < StrbWidth; i++) begin
            dataMasked[i*8 +: 8] = baseMask[i] ? wr_data_i[i*8 +: 8] : 8'h00;
        end
        wStrb_d  = {{StrbWidth{1'b0}}, baseMask} << offset;
        wData_d  = {{AXI_DATA_WIDTH{1'b0}}, dataMasked} << {offset, 3'b000};
        cross_d  = |wStrb_d[2*StrbWidth-1:StrbWidth];
        awAddr_d = {wr_addr_i[AXI_ADDR_WIDTH-1:3], 3'b000};
    end

    // The final beat is beat 0 for a single-beat store, beat 1 for a crossing one
    assign lastBeat = (beat_q == cross_q);

    // Transaction FSM: state, registered valids/readies, beat counter and payload
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            awValid_q <= 1'b0;
            wValid_q  <= 1'b0;
            bReady_q  <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            beat_q    <= 1'b0;
            awAddr_q  <= '0;
            cross_q   <= 1'b0;
            wData_q   <= '0;
            wStrb_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    beat_q <= 1'b0;
                    if (wr_addr_valid_i) begin
                        state_q   <= ADDR;
                        awValid_q <= 1'b1;
                        err_q     <= 1'b0;
                        awAddr_q  <= awAddr_d;
                        cross_q   <= cross_d;
                        wData_q   <= wData_d;
                        wStrb_q   <= wStrb_d;
                    end
                end
                ADDR: begin
                    if (axi_aw_ready_i) begin
                        state_q   <= WRITE;
                        awValid_q <= 1'b0;
                        wValid_q  <= 1'b1;
                    end
                end
                WRITE: begin
                    if (axi_w_ready_i) begin
                        if (lastBeat) begin
                            state_q  <= RESP;
                            wValid_q <= 1'b0;
                            bReady_q <= 1'b1;
                        end else begin
                            beat_q <= beat_q + 1'b1;
                        end
                    end
                end
                RESP: begin
                    if (axi_b_valid_i) begin
                        state_q  <= DONE;
                        bReady_q <= 1'b0;
                        done_q   <= 1'b1;
                        err_q    <= (axi_b_resp_i != 2'b00);
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q   <= IDLE;
                    awValid_q <= 1'b0;
                    wValid_q  <= 1'b0;
                    bReady_q  <= 1'b0;
                    done_q    <= 1'b0;
                end
            endcase
        end
    end

    assign wr_done_o      = done_q;
    assign wr_err_o       = err_q;

    assign axi_aw_valid_o = awValid_q;
    assign axi_aw_addr_o  = awAddr_q;
    assign axi_aw_id_o    = '0;
    assign axi_aw_user_o  = '0;
    assign axi_aw_len_o   = {7'b0, cross_q};
    assign axi_aw_size_o  = 3'b011;
    assign axi_aw_burst_o = 2'b01;
    assign axi_aw_prot_o  = 3'b000;
    assign axi_aw_lock_o  = 1'b0;
    assign axi_aw_cache_o = 4'b0000;
    assign axi_aw_qos_o   = 4'b0000;

    assign axi_w_valid_o  = wValid_q;
    assign axi_w_data_o   = beat_q ? wData_q[2*AXI_DATA_WIDTH-1:AXI_DATA_WIDTH]
                                   : wData_q[AXI_DATA_WIDTH-1:0];
    assign axi_w_strb_o   = beat_q ? wStrb_q[2*StrbWidth-1:StrbWidth]
                                   : wStrb_q[StrbWidth-1:0];
    assign axi_w_last_o   = wValid_q & lastBeat;
    assign axi_w_user_o   = '0;

    assign axi_b_ready_o  = bReady_q;

    // Response ID/USER and the reserved size bit carry no meaning here
    assign unused_inputs  = ^{axi_b_id_i, axi_b_user_i, wr_size_i[2]};

endmodule

// File: tb/tb_ysyx_22040759_wraxi.sv
// tb_ysyx_22040759_wraxi: directed, table-driven bench for the AXI write initiator.
// A small slave model drives AW/W/B readiness and response with configurable
// stalls and checks every beat against hand-computed lane data and strobes.

module tb_ysyx_22040759_wraxi;

    logic        clk;
    logic        rst;
    logic        wr_addr_valid_i;
    logic [31:0] wr_addr_i;
    logic [2:0]  wr_size_i;
    logic [63:0] wr_data_i;
    logic        wr_done_o;
    logic        wr_err_o;
    logic        axi_aw_ready_i;
    logic        axi_aw_valid_o;
    logic [31:0] axi_aw_addr_o;
    logic [3:0]  axi_aw_id_o;
    logic [0:0]  axi_aw_user_o;
    logic [7:0]  axi_aw_len_o;
    logic [2:0]  axi_aw_size_o;
    logic [1:0]  axi_aw_burst_o;
    logic [2:0]  axi_aw_prot_o;
    logic        axi_aw_lock_o;
    logic [3:0]  axi_aw_cache_o;
    logic [3:0]  axi_aw_qos_o;
    logic        axi_w_ready_i;
    logic        axi_w_valid_o;
    logic [63:0] axi_w_data_o;
    logic [7:0]  axi_w_strb_o;
    logic        axi_w_last_o;
    logic [0:0]  axi_w_user_o;
    logic        axi_b_ready_o;
    logic        axi_b_valid_i;
    logic [1:0]  axi_b_resp_i;
    logic [3:0]  axi_b_id_i;
    logic [0:0]  axi_b_user_i;

    int checks;
    int failures;

    typedef struct {
        logic [31:0] addr;
        logic [2:0]  size;
        logic [63:0] data;
        logic [31:0] expAddr;
        logic        expLen;
        logic [63:0] expData0;
        logic [7:0]  expStrb0;
        logic [63:0] expData1;
        logic [7:0]  expStrb1;
    } vec_t;

    vec_t vecs[8];

    ysyx_22040759_wraxi dut (
        .clk             (clk),
        .rst             (rst),
        .wr_addr_valid_i (wr_addr_valid_i),
        .wr_addr_i       (wr_addr_i),
        .wr_size_i       (wr_size_i),
        .wr_data_i       (wr_data_i),
        .wr_done_o       (wr_done_o),
        .wr_err_o        (wr_err_o),
        .axi_aw_ready_i  (axi_aw_ready_i),
        .axi_aw_valid_o  (axi_aw_valid_o),
        .axi_aw_addr_o   (axi_aw_addr_o),
        .axi_aw_id_o     (axi_aw_id_o),
        .axi_aw_user_o   (axi_aw_user_o),
        .axi_aw_len_o    (axi_aw_len_o),
        .axi_aw_size_o   (axi_aw_size_o),
        .axi_aw_burst_o  (axi_aw_burst_o),
        .axi_aw_prot_o   (axi_aw_prot_o),
        .axi_aw_lock_o   (axi_aw_lock_o),
        .axi_aw_cache_o  (axi_aw_cache_o),
        .axi_aw_qos_o    (axi_aw_qos_o),
        .axi_w_ready_i   (axi_w_ready_i),
        .axi_w_valid_o   (axi_w_valid_o),
        .axi_w_data_o    (axi_w_data_o),
        .axi_w_strb_o    (axi_w_strb_o),
        .axi_w_last_o    (axi_w_last_o),
        .axi_w_user_o    (axi_w_user_o),
        .axi_b_ready_o   (axi_b_ready_o),
        .axi_b_valid_i   (axi_b_valid_i),
        .axi_b_resp_i    (axi_b_resp_i),
        .axi_b_id_i      (axi_b_id_i),
        .axi_b_user_i    (axi_b_user_i)
    );

    // Free-running 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [127:0] actual,
                               input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        wr_addr_valid_i = 1'b1;
        wr_addr_i       = v.addr;
        wr_size_i       = v.size;
        wr_data_i       = v.data;
    endtask

    // One full transaction against the slave model. Cycle 0 is the cycle the
    // request is first presented; outputs are sampled on the falling edge.
    task automatic runTxn(input vec_t v, input int awStall, input int wStall,
                          input int bDelay, input logic [1:0] bresp,
                          input logic expErr, input int expDone);
        int cycle, awWait, wWait, bWait, beat, doneCount, doneCycle;
        bit awDone, wDone, bDone, finished;
        bit awHs, wHs, bHs;
        logic expLast;
        cycle = 0; awWait = 0; wWait = 0; bWait = 0; beat = 0;
        doneCount = 0; doneCycle = 0;
        awDone = 0; wDone = 0; bDone = 0; finished = 0;
        @(negedge clk);
        applyStimulus(v);
        axi_aw_ready_i = 1'b0;
        axi_w_ready_i  = 1'b0;
        axi_b_valid_i  = 1'b0;
        axi_b_resp_i   = bresp;
        while (!finished && cycle < 80) begin
            @(negedge clk);
            cycle++;
            awHs = 0; wHs = 0; bHs = 0;
            if (cycle == 1) checkOutput("aw_valid_cycle1", axi_aw_valid_o, 1);
            if (!awDone) begin
                checkOutput("aw_valid_held", axi_aw_valid_o, 1);
                checkOutput("w_not_early", axi_w_valid_o, 0);
            end
            if (awDone && !wDone) checkOutput("w_valid_held", axi_w_valid_o, 1);
            if (wDone && !bDone) checkOutput("b_ready_held", axi_b_ready_o, 1);
            if (wr_done_o) begin
                doneCount++;
                if (doneCount == 1) begin
                    doneCycle = cycle;
                    if (expDone > 0) checkOutput("done_cycle", cycle, expDone);
                    checkOutput("done_after_b", bDone, 1);
                    checkOutput("wr_err", wr_err_o, expErr);
                end
                wr_addr_valid_i = 1'b0;
            end else if (doneCount > 0 && cycle == doneCycle + 1) begin
                checkOutput("idle_after_done", {axi_aw_valid_o, axi_w_valid_o, axi_b_ready_o}, 0);
                finished = 1;
            end
            if (axi_aw_valid_o) begin
                checkOutput("aw_addr", axi_aw_addr_o, v.expAddr);
                checkOutput("aw_len", axi_aw_len_o, {7'b0, v.expLen});
                checkOutput("aw_const", {axi_aw_id_o, axi_aw_user_o, axi_aw_size_o,
                            axi_aw_burst_o, axi_aw_prot_o, axi_aw_lock_o,
                            axi_aw_cache_o, axi_aw_qos_o, axi_w_user_o},
                            {4'h0, 1'b0, 3'b011, 2'b01, 3'b000, 1'b0, 4'h0, 4'h0, 1'b0});
                axi_aw_ready_i = (awWait >= awStall);
                awWait++;
                awHs = axi_aw_ready_i;
            end else begin
                axi_aw_ready_i = 1'b0;
            end
            if (axi_w_valid_o) begin
                expLast = (beat == int'(v.expLen));
                checkOutput("w_data", axi_w_data_o, (beat == 0) ? v.expData0 : v.expData1);
                checkOutput("w_strb", axi_w_strb_o, (beat == 0) ? v.expStrb0 : v.expStrb1);
                checkOutput("w_last", axi_w_last_o, expLast);
                axi_w_ready_i = (wWait >= wStall);
                wWait++;
                if (axi_w_ready_i) begin
                    beat++;
                    wWait = 0;
                    wHs = expLast;
                end
            end else begin
                axi_w_ready_i = 1'b0;
            end
            if (wDone && !bDone) begin
                axi_b_valid_i = (bWait >= bDelay);
                bWait++;
                bHs = axi_b_valid_i && axi_b_ready_o;
            end else begin
                axi_b_valid_i = 1'b0;
            end
            awDone = awDone | awHs;
            wDone  = wDone | wHs;
            bDone  = bDone | bHs;
        end
        if (!finished) begin
            failures++;
            $display("[TB] FAIL txn_timeout: got no completion within 80 cycles, expected wr_done_o");
        end
        checkOutput("done_pulses", doneCount, 1);
        axi_aw_ready_i = 1'b0;
        axi_w_ready_i  = 1'b0;
        axi_b_valid_i  = 1'b0;
        wr_addr_valid_i = 1'b0;
    endtask

    initial begin
        bit seen;
        checks   = 0;
        failures = 0;

        //            addr          size    data                    expAddr       len   data0                   strb0  data1                   strb1
        vecs[0] = '{32'h8000_0010, 3'b011, 64'h1122334455667788, 32'h8000_0010, 1'b0, 64'h1122334455667788, 8'hFF, 64'h0, 8'h00};
        vecs[1] = '{32'h8000_0005, 3'b000, 64'h00000000FFFFFF5A, 32'h8000_0000, 1'b0, 64'h00005A0000000000, 8'h20, 64'h0, 8'h00};
        vecs[2] = '{32'h8000_0006, 3'b010, 64'h00000000DDCCBBAA, 32'h8000_0000, 1'b1, 64'hBBAA000000000000, 8'hC0, 64'h000000000000DDCC, 8'h03};
        vecs[3] = '{32'h8000_0007, 3'b001, 64'h123456789ABCBEEF, 32'h8000_0000, 1'b1, 64'hEF00000000000000, 8'h80, 64'h00000000000000BE, 8'h01};
        vecs[4] = '{32'h8000_1003, 3'b011, 64'h0807060504030201, 32'h8000_1000, 1'b1, 64'h0504030201000000, 8'hF8, 64'h0000000000080706, 8'h07};
        vecs[5] = '{32'h8000_0004, 3'b010, 64'hFFFFFFFFCAFEF00D, 32'h8000_0000, 1'b0, 64'hCAFEF00D00000000, 8'hF0, 64'h0, 8'h00};
        vecs[6] = '{32'h8000_000B, 3'b100, 64'h0000000000001177, 32'h8000_0008, 1'b0, 64'h0000000077000000, 8'h08, 64'h0, 8'h00};
        vecs[7] = '{32'h0000_0016, 3'b001, 64'h000000000000A1B2, 32'h0000_0010, 1'b0, 64'hA1B2000000000000, 8'hC0, 64'h0, 8'h00};

        rst = 1'b1;
        wr_addr_valid_i = 1'b0; wr_addr_i = '0; wr_size_i = '0; wr_data_i = '0;
        axi_aw_ready_i = 1'b0; axi_w_ready_i = 1'b0; axi_b_valid_i = 1'b0;
        axi_b_resp_i = 2'b00; axi_b_id_i = '0; axi_b_user_i = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset_outputs",
                    {axi_aw_valid_o, axi_w_valid_o, axi_b_ready_o, wr_done_o, wr_err_o}, 0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("idle_outputs",
                    {axi_aw_valid_o, axi_w_valid_o, axi_b_ready_o, wr_done_o, wr_err_o}, 0);

        // Table of stores with an always-ready slave and B one cycle after last W
        for (int i = 0; i < 8; i++) begin
            runTxn(vecs[i], 0, 0, 0, 2'b00, 1'b0, 4 + int'(vecs[i].expLen));
        end

        // Backpressure on every channel for a crossing store
        runTxn(vecs[2], 3, 2, 4, 2'b00, 1'b0, 16);

        // Error response, then a clean transaction clears the error
        runTxn(vecs[0], 0, 0, 0, 2'b10, 1'b1, 4);
        runTxn(vecs[1], 0, 0, 0, 2'b00, 1'b0, 4);

        // Reset while the W channel is stalled
        @(negedge clk);
        applyStimulus(vecs[2]);
        axi_aw_ready_i = 1'b1;
        axi_w_ready_i  = 1'b0;
        seen = 0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            if (axi_w_valid_o) seen = 1;
        end
        checkOutput("reached_write", seen, 1);
        rst = 1'b1;
        wr_addr_valid_i = 1'b0;
        axi_aw_ready_i  = 1'b0;
        @(negedge clk);
        checkOutput("rst_mid_write",
                    {axi_aw_valid_o, axi_w_valid_o, axi_b_ready_o, wr_done_o}, 0);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checkOutput("no_done_after_rst", {wr_done_o, axi_aw_valid_o}, 0);
        end
        runTxn(vecs[2], 0, 0, 0, 2'b00, 1'b0, 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
